gcd_result_bcd: RTL and testbench

Sequential binary-to-BCD converter directly downstream of the GCD engine. It captures the engine's 8-bit GCD result and converts it to three BCD digits (hundreds, tens, ones) with an iterative shift-and-add-3 (double-dabble) state machine. The digits feed the seven-segment display driver. The block's Start/Ack handshake pairs with the engine's done/acknowledge handshake.

---
 rtl/gcd_result_bcd.sv | 94 +++++++++
 tb/tb_gcd_result_bcd.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gcd_result_bcd.sv
// Iterative double-dabble converter: 8-bit GCD result to three BCD digits.
// Optional leading-zero blanking of the digit enables when ZERO_BLANK_EN is defined.
module gcd_result_bcd (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CEN,
  input  logic       Start,
  input  logic       Ack,
  input  logic [7:0] Value,
  output logic [3:0] Hundreds,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic [2:0] Dig_En,
  output logic       q_I,
  output logic       q_Adj,
  output logic       q_Shift,
  output logic       q_Done
);

  typedef enum logic [3:0] {
    I     = 4'b0001,
    ADJ   = 4'b0010,
    SHIFT = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t      state, next_state;
  logic [7:0]  v;
  logic [2:0]  cnt;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= I;
    else       state <= next_state;
  end

  // Illegal encodings fall into an unknown state that only Reset clears.
  always_comb begin
    next_state = state;
    case (state)
      I:       if (Start) next_state = ADJ;
      ADJ:     if (CEN)   next_state = SHIFT;
      SHIFT:   if (CEN)   next_state = (cnt == 3'd7) ? DONE : ADJ;
      DONE:    if (Ack)   next_state = I;
      default: next_state = state_t'(4'bxxxx);
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v        <= 8'd0;
      cnt      <= 3'd0;
      Hundreds <= 4'd0;
      Tens     <= 4'd0;
      Ones     <= 4'd0;
    end else begin
      case (state)
        I: if (Start) begin
          v        <= Value;
          cnt      <= 3'd0;
          Hundreds <= 4'd0;
          Tens     <= 4'd0;
          Ones     <= 4'd0;
        end
        ADJ: if (CEN) begin
          Hundreds <= adj3(Hundreds);
          Tens     <= adj3(Tens);
          Ones     <= adj3(Ones);
        end
        // The hundreds MSB is always 0 here, so dropping it loses nothing.
        SHIFT: if (CEN) begin
          {Hundreds, Tens, Ones, v} <= {Hundreds[2:0], Tens, Ones, v, 1'b0};
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ZERO_BLANK_EN
  assign Dig_En = {Hundreds != 4'd0, (Hundreds != 4'd0) || (Tens != 4'd0), 1'b1};
`else
  assign Dig_En = 3'b111;
`endif

  assign q_I     = state[0];
  assign q_Adj   = state[1];
  assign q_Shift = state[2];
  assign q_Done  = state[3];

endmodule

// File: tb/tb_gcd_result_bcd.sv
// Self-checking bench for gcd_result_bcd: directed and random conversions
// compared against decimal arithmetic and a step-count model of the handshake.
module tb_gcd_result_bcd;

  logic       Clk = 1'b0;
  logic       Reset, CEN, Start, Ack;
  logic [7:0] Value;
  logic [3:0] Hundreds, Tens, Ones;
  logic [2:0] Dig_En;
  logic       q_I, q_Adj, q_Shift, q_Done;

  int checks = 0;
  int fails  = 0;

  gcd_result_bcd dut (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Value(Value), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
    .Dig_En(Dig_En), .q_I(q_I), .q_Adj(q_Adj), .q_Shift(q_Shift), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] expEn(input int v);
`ifdef ZERO_BLANK_EN
    return {v >= 100, v >= 10, 1'b1};
`else
    return (v >= 0) ? 3'b111 : 3'b111;
`endif
  endfunction

  // Expected {q_Done,q_Shift,q_Adj,q_I} after k enabled steps since the load.
  function automatic logic [3:0] expState(input int k);
    if (k >= 16) return 4'b1000;
    return (k % 2 == 0) ? 4'b0010 : 4'b0100;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // mode 0: CEN held high; 1: CEN toggling; 2: Start/Value noise with Ack held high.
  task automatic applyStimulus(input logic [7:0] val, input int mode, output int edges);
    int  k;
    int  vi;
    bit  en;
    vi    = int'(val);
    Value = val;
    Start = 1'b1;
    Ack   = 1'b0;
    CEN   = (mode == 1) ? 1'b0 : 1'b1;
    tick;
    edges = 1;
    k     = 0;
    Start = 1'b0;
    checkOutput("load_state", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'(expState(0)));
    while (k < 16 && edges < 100) begin
      en  = (mode == 1) ? ~CEN : 1'b1;
      CEN = en;
      if (mode == 2) begin
        Start = 1'($urandom_range(0, 1));
        Value = 8'($urandom);
        Ack   = 1'b1;
      end
      tick;
      edges++;
      if (en) k++;
      checkOutput("state_flags", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'(expState(k)));
      if (k < 16 && k % 2 == 0)
        checkOutput("partial_digits", {4'd0, Hundreds, Tens, Ones}, {4'd0, bcd(vi >> (8 - k / 2))});
    end
    Start = 1'b0;
    Ack   = 1'b0;
    CEN   = 1'b1;
  endtask

  task automatic checkResult(input logic [7:0] val, input int mode, input bit doAck);
    int edges;
    applyStimulus(val, mode, edges);
    if (mode != 1) checkOutput("latency_edges", 16'(edges), 16'd17);
    else           checkOutput("latency_edges", 16'(edges), 16'd32);
    checkOutput("digits", {4'd0, Hundreds, Tens, Ones}, {4'd0, bcd(int'(val))});
    checkOutput("dig_en", {13'd0, Dig_En}, {13'd0, expEn(int'(val))});
    if (doAck) begin
      Ack = 1'b1;
      tick;
      Ack = 1'b0;
      checkOutput("ack_to_idle", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'h0001);
      checkOutput("hold_digits", {4'd0, Hundreds, Tens, Ones}, {4'd0, bcd(int'(val))});
    end
  endtask

  initial begin
    int v;
    Reset = 1'b1;
    CEN   = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    Value = 8'd0;
    #12;
    checkOutput("reset_state", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'h0001);
    checkOutput("reset_digits", {4'd0, Hundreds, Tens, Ones}, 16'h0000);
    checkOutput("reset_dig_en", {13'd0, Dig_En}, {13'd0, expEn(0)});
    Reset = 1'b0;
    tick;

    checkResult(8'd255, 0, 1'b1);
    checkResult(8'd0,   0, 1'b1);
    checkResult(8'd9,   0, 1'b1);
    checkResult(8'd100, 0, 1'b1);
    checkResult(8'd128, 1, 1'b1);
    checkResult(8'd173, 2, 1'b1);

    // Asynchronous reset after the 4th shift, then a fresh conversion.
    Value = 8'd200;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    checkOutput("pre_reset_digits", {4'd0, Hundreds, Tens, Ones}, {4'd0, bcd(200 >> 4)});
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_reset_state", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'h0001);
    checkOutput("async_reset_digits", {4'd0, Hundreds, Tens, Ones}, 16'h0000);
    tick;
    Reset = 1'b0;
    checkResult(8'd37, 0, 1'b0);

    // Start and Ack together in DONE: only Ack acts, no load.
    Value = 8'd200;
    Start = 1'b1;
    Ack   = 1'b1;
    tick;
    Start = 1'b0;
    Ack   = 1'b0;
    checkOutput("start_ack_state", {12'd0, q_Done, q_Shift, q_Adj, q_I}, 16'h0001);
    checkOutput("start_ack_digits", {4'd0, Hundreds, Tens, Ones}, {4'd0, bcd(37)});
    checkResult(8'd200, 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 255));
      checkResult(8'(v), i % 3, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
